// File: rtl/stream_xbar_switch.sv
// stream_xbar_switch
//   Fully connected valid/ready stream crossbar. Each input carries a payload
//   and a destination select. Each output round-robin arbitrates among the
//   inputs that target it, and reports which input the current beat came from.
//   An optional two-slot spill register per output cuts the combinational
//   ready path.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   flush_i  : synchronous clear of round-robin pointers and locks
//   rr_i     : per-output external priority pointer (used when ExtPrio=1)
//   data_i   : per-input payload
//   sel_i    : per-input destination output
//   valid_i  : per-input valid
//   ready_o  : per-input ready (grant from the selected output)
//   data_o   : per-output payload
//   idx_o    : per-output source input index of data_o
//   valid_o  : per-output valid
//   ready_i  : per-output downstream ready
module stream_xbar_switch #(
  parameter int unsigned NumInp      = 0,
  parameter int unsigned NumOut      = 0,
  parameter int unsigned DataWidth   = 1,
  parameter bit          OutSpillReg = 1'b0,
  parameter bit          ExtPrio     = 1'b0,
  parameter bit          AxiVldRdy   = 1'b1,
  parameter bit          LockIn      = 1'b1,
  // Port counts clamped to at least one so an unconfigured instance still elaborates.
  localparam int unsigned NI       = (NumInp > 0) ? NumInp : 1,
  localparam int unsigned NO       = (NumOut > 0) ? NumOut : 1,
  localparam int unsigned SelWidth = (NO > 1) ? $clog2(NO) : 1,
  localparam int unsigned IdxWidth = (NI > 1) ? $clog2(NI) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic [NO-1:0][IdxWidth-1:0]       rr_i,
  input  logic [NI-1:0][DataWidth-1:0]      data_i,
  input  logic [NI-1:0][SelWidth-1:0]       sel_i,
  input  logic [NI-1:0]                     valid_i,
  output logic [NI-1:0]                     ready_o,
  output logic [NO-1:0][DataWidth-1:0]      data_o,
  output logic [NO-1:0][IdxWidth-1:0]       idx_o,
  output logic [NO-1:0]                     valid_o,
  input  logic [NO-1:0]                     ready_i
);

  typedef logic [IdxWidth-1:0]  idx_t;
  typedef logic [DataWidth-1:0] data_t;

  // Grant of output j towards input i.
  logic [NO-1:0][NI-1:0] gnt_all;

  for (genvar j = 0; j < NO; j++) begin : g_out
    logic [NI-1:0] req;
    idx_t          rr_q;
    idx_t          lock_idx_q;
    logic          lock_q;
    idx_t          ptr;
    idx_t          win;
    logic          found;
    logic          arb_valid;
    logic          arb_ready;
    data_t         arb_data;
    logic          hs;
    logic [NI-1:0] gnt;

    always_comb begin
      req = '0;
      for (int unsigned i = 0; i < NI; i++) begin
        req[i] = valid_i[i] && (sel_i[i] == SelWidth'(j));
      end
    end

    // Cyclic search starting at the pointer; with nothing requesting the
    // winner defaults to the pointer position. A held lock overrides.
    always_comb begin
      ptr   = ExtPrio ? rr_i[j] : rr_q;
      win   = idx_t'(32'(ptr) % NI);
      found = 1'b0;
      for (int unsigned k = 0; k < NI; k++) begin
        if (!found && req[idx_t'((32'(ptr) + k) % NI)]) begin
          win   = idx_t'((32'(ptr) + k) % NI);
          found = 1'b1;
        end
      end
      if (LockIn && lock_q) begin
        win = lock_idx_q;
      end
    end

    assign arb_valid = req[win];
    assign arb_data  = data_i[win];
    assign hs        = arb_valid && arb_ready;

    always_comb begin
      gnt = '0;
      for (int unsigned i = 0; i < NI; i++) begin
        gnt[i] = arb_ready && (win == idx_t'(i)) && (req[i] || !AxiVldRdy);
      end
    end
    assign gnt_all[j] = gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rr_q       <= '0;
        lock_q     <= 1'b0;
        lock_idx_q <= '0;
      end else if (flush_i) begin
        rr_q       <= '0;
        lock_q     <= 1'b0;
        lock_idx_q <= '0;
      end else begin
        if (hs) begin
          rr_q <= (rr_q == idx_t'(NI - 1)) ? '0 : rr_q + idx_t'(1);
        end
        lock_q <= LockIn && arb_valid && !arb_ready;
        if (arb_valid && !arb_ready) begin
          lock_idx_q <= win;
        end
      end
    end

    if (OutSpillReg) begin : g_spill
      logic  a_full_q, b_full_q;
      data_t a_data_q, b_data_q;
      idx_t  a_idx_q, b_idx_q;
      logic  a_fill, a_drain, b_fill, b_drain;

      // Slot A is free whenever it is empty or slot B can absorb its beat,
      // which keeps one beat per cycle without looking at ready_i.
      assign arb_ready = !a_full_q || !b_full_q;
      assign a_fill    = arb_valid && arb_ready;
      assign a_drain   = a_full_q && !b_full_q;
      assign b_fill    = a_drain && !ready_i[j];
      assign b_drain   = b_full_q && ready_i[j];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          a_full_q <= 1'b0;
          b_full_q <= 1'b0;
          a_data_q <= '0;
          b_data_q <= '0;
          a_idx_q  <= '0;
          b_idx_q  <= '0;
        end else begin
          a_full_q <= a_fill || (a_full_q && !a_drain);
          b_full_q <= b_fill || (b_full_q && !b_drain);
          if (a_fill) begin
            a_data_q <= arb_data;
            a_idx_q  <= win;
          end
          if (b_fill) begin
            b_data_q <= a_data_q;
            b_idx_q  <= a_idx_q;
          end
        end
      end

      assign valid_o[j] = a_full_q || b_full_q;
      assign data_o[j]  = b_full_q ? b_data_q : a_data_q;
      assign idx_o[j]   = b_full_q ? b_idx_q : a_idx_q;
    end else begin : g_bypass
      assign arb_ready  = ready_i[j];
      assign valid_o[j] = arb_valid;
      assign data_o[j]  = arb_data;
      assign idx_o[j]   = win;
    end
  end

  // An out-of-range select matches no output and therefore is never readied.
  always_comb begin
    ready_o = '0;
    for (int unsigned i = 0; i < NI; i++) begin
      for (int unsigned j = 0; j < NO; j++) begin
        if (sel_i[i] == SelWidth'(j)) begin
          ready_o[i] = gnt_all[j][i];
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_xbar_switch.sv
module tb_stream_xbar_switch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic flush;
  int   mode;  // 0: bypass DUT, 1: spill DUT, 2: external-priority DUT

  logic [2:0][7:0] data;
  logic [2:0][0:0] sel;
  logic [2:0]      valid;
  logic [1:0]      rdy_out;
  logic [0:0][1:0] rr_e;

  logic [2:0]      valid_b, valid_s, valid_e;
  logic [2:0]      ready_o_b, ready_o_s, ready_o_e;
  logic [1:0][7:0] data_o_b, data_o_s;
  logic [1:0][1:0] idx_o_b, idx_o_s;
  logic [1:0]      valid_o_b, valid_o_s;
  logic [0:0][7:0] data_o_e;
  logic [0:0][1:0] idx_o_e;
  logic [0:0]      valid_o_e;
  logic [2:0][0:0] sel_e;
  logic [1:0][1:0] rr_zero;

  assign valid_b = (mode == 0) ? valid : '0;
  assign valid_s = (mode == 1) ? valid : '0;
  assign valid_e = (mode == 2) ? valid : '0;
  assign sel_e   = '0;
  assign rr_zero = '0;

  stream_xbar_switch #(
    .NumInp(3), .NumOut(2), .DataWidth(8), .OutSpillReg(1'b0),
    .ExtPrio(1'b0), .AxiVldRdy(1'b1), .LockIn(1'b1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rr_i(rr_zero),
    .data_i(data), .sel_i(sel), .valid_i(valid_b), .ready_o(ready_o_b),
    .data_o(data_o_b), .idx_o(idx_o_b), .valid_o(valid_o_b), .ready_i(rdy_out)
  );

  stream_xbar_switch #(
    .NumInp(3), .NumOut(2), .DataWidth(8), .OutSpillReg(1'b1),
    .ExtPrio(1'b0), .AxiVldRdy(1'b1), .LockIn(1'b1)
  ) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rr_i(rr_zero),
    .data_i(data), .sel_i(sel), .valid_i(valid_s), .ready_o(ready_o_s),
    .data_o(data_o_s), .idx_o(idx_o_s), .valid_o(valid_o_s), .ready_i(rdy_out)
  );

  stream_xbar_switch #(
    .NumInp(3), .NumOut(1), .DataWidth(8), .OutSpillReg(1'b0),
    .ExtPrio(1'b1), .AxiVldRdy(1'b1), .LockIn(1'b1)
  ) dut_e (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .rr_i(rr_e),
    .data_i(data), .sel_i(sel_e), .valid_i(valid_e), .ready_o(ready_o_e),
    .data_o(data_o_e), .idx_o(idx_o_e), .valid_o(valid_o_e), .ready_i(1'b1)
  );

  logic [2:0]      cur_ready;
  logic [1:0]      mon_valid;
  logic [1:0][7:0] mon_data;
  logic [1:0][1:0] mon_idx;
  assign cur_ready = (mode == 0) ? ready_o_b : (mode == 1) ? ready_o_s : ready_o_e;
  assign mon_valid = (mode == 0) ? valid_o_b : (mode == 1) ? valid_o_s : 2'b00;
  assign mon_data  = (mode == 1) ? data_o_s : data_o_b;
  assign mon_idx   = (mode == 1) ? idx_o_s : idx_o_b;

  int checks = 0;
  int errors = 0;

  // Expected beats per output: {idx[1:0], data[7:0]}.
  logic [9:0] exp0[$];
  logic [9:0] exp1[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Holds one beat on input i until it is accepted (bounded wait).
  task automatic send(input int i, input logic s, input logic [7:0] d);
    int n;
    n = 0;
    sel[i]   = s;
    data[i]  = d;
    valid[i] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!cur_ready[i] && n < 50);
    if (!cur_ready[i]) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in%0d got=no_ready expected=ready", i);
    end
    @(posedge clk);
    #1;
    valid[i] = 1'b0;
  endtask

  task automatic monitor;
    logic [9:0] e;
    logic [9:0] g;
    forever begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        if (mon_valid[j] && rdy_out[j]) begin
          g = {mon_idx[j], mon_data[j]};
          if ((j == 0 && exp0.size() == 0) || (j == 1 && exp1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat out%0d got=%0h expected=none", j, g);
          end else begin
            e = (j == 0) ? exp0.pop_front() : exp1.pop_front();
            check($sformatf("beat_out%0d", j), 32'(g), 32'(e));
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] r;
    rst_n = 1'b0; flush = 1'b0; mode = 0;
    data = '0; sel = '0; valid = '0; rdy_out = 2'b11; rr_e = '0;
    fork monitor(); join_none
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    @(negedge clk);
    check("rst_valid_b", 32'(valid_o_b), 0);
    check("rst_valid_s", 32'(valid_o_s), 0);
    check("rst_data_s", 32'(data_o_s), 0);
    check("rst_idx_s", 32'(idx_o_s), 0);
    tick();

    // Two inputs to two different outputs in the same cycle
    exp1.push_back({2'd0, 8'h0A});
    exp0.push_back({2'd1, 8'h0B});
    sel[0] = 1'b1; data[0] = 8'h0A; valid[0] = 1'b1;
    sel[1] = 1'b0; data[1] = 8'h0B; valid[1] = 1'b1;
    @(negedge clk);
    check("parallel_ready", 32'(ready_o_b), 32'h3);
    tick();
    valid = '0;

    flush = 1'b1; tick(); flush = 1'b0;

    // Contention on output 0: grants rotate 0,1,2,0 from the flushed pointer
    exp0.push_back({2'd0, 8'h10});
    exp0.push_back({2'd1, 8'h11});
    exp0.push_back({2'd2, 8'h12});
    exp0.push_back({2'd0, 8'h13});
    fork
      begin send(0, 1'b0, 8'h10); send(0, 1'b0, 8'h13); end
      send(1, 1'b0, 8'h11);
      send(2, 1'b0, 8'h12);
      repeat (4) begin
        @(negedge clk);
        check("contention_onehot", 32'($onehot(ready_o_b)), 1);
      end
    join

    flush = 1'b1; tick(); flush = 1'b0;

    // Stall with lock: in1 holds output 0 even after in0 (higher priority) arrives
    exp0.push_back({2'd1, 8'h21});
    exp0.push_back({2'd0, 8'h20});
    rdy_out[0] = 1'b0;
    fork
      send(1, 1'b0, 8'h21);
      begin tick(); send(0, 1'b0, 8'h20); end
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_valid", 32'(valid_o_b[0]), 1);
          check("stall_idx", 32'(idx_o_b[0]), 1);
          check("stall_data", 32'(data_o_b[0]), 32'h21);
          check("stall_ready", 32'(ready_o_b), 0);
        end
        @(posedge clk); #1;
        rdy_out[0] = 1'b1;
        @(negedge clk);
        check("stall_release_ready", 32'(ready_o_b), 32'h2);
      end
    join
    tick();

    // External priority pointer
    mode = 2;
    rr_e[0] = 2'd2;
    data[0] = 8'h40; data[2] = 8'h42; valid[0] = 1'b1; valid[2] = 1'b1;
    @(negedge clk);
    check("extprio2_ready", 32'(ready_o_e), 32'h4);
    check("extprio2_idx", 32'(idx_o_e), 2);
    check("extprio2_data", 32'(data_o_e), 32'h42);
    check("extprio2_valid", 32'(valid_o_e), 1);
    rr_e[0] = 2'd0;
    #1;
    check("extprio0_ready", 32'(ready_o_e), 32'h1);
    check("extprio0_idx", 32'(idx_o_e), 0);
    tick();
    valid = '0;
    tick();

    // Spill register: one-cycle latency, toggling downstream ready
    mode = 1;
    for (int k = 0; k < 6; k++) exp0.push_back({2'd0, 8'h30 + 8'(k)});
    fork
      begin for (int k = 0; k < 6; k++) send(0, 1'b0, 8'h30 + 8'(k)); end
      begin
        @(negedge clk);
        check("spill_lat_first", 32'(valid_o_s[0]), 0);
        @(negedge clk);
        check("spill_lat_second", 32'(valid_o_s[0]), 1);
      end
      begin
        for (int k = 0; k < 12; k++) begin
          @(posedge clk); #1;
          rdy_out[0] = (k % 2 == 0) ? 1'b0 : 1'b1;
          @(negedge clk); #2;
          r = ready_o_s;
          rdy_out[0] = ~rdy_out[0];
          #1;
          check("spill_no_comb_path", 32'(ready_o_s), 32'(r));
          rdy_out[0] = ~rdy_out[0];
        end
        @(posedge clk); #1;
        rdy_out[0] = 1'b1;
      end
    join
    repeat (4) tick();
    check("spill_all_delivered", exp0.size(), 0);

    // Reset with a beat parked in the spill register
    rdy_out[0] = 1'b0;
    send(0, 1'b0, 8'h55);
    @(negedge clk);
    check("parked_valid", 32'(valid_o_s[0]), 1);
    check("parked_data", 32'(data_o_s[0]), 32'h55);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(valid_o_s), 0);
    check("async_rst_data", 32'(data_o_s), 0);
    check("async_rst_idx", 32'(idx_o_s), 0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst_valid", 32'(valid_o_s), 0);
    rdy_out[0] = 1'b1;
    tick();

    check("queue0_empty", exp0.size(), 0);
    check("queue1_empty", exp1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
